// File: rtl/nmos_clk_pkg.sv
// ---------------------------------------------------------------------------
// nmos_clk_pkg
// Shared definitions for the NMOS two-phase clock generator.
//   - clk_state_e : one-hot state encoding (IDLE, PH1, GAP1, PH2, GAP2)
//   - DEF_*       : default phase lengths and counter widths. The cell library
//                   and its benches pick these up so they agree on the
//                   machine-cycle period.
// ---------------------------------------------------------------------------
package nmos_clk_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_PH1  = 5'b00010,
    ST_GAP1 = 5'b00100,
    ST_PH2  = 5'b01000,
    ST_GAP2 = 5'b10000
  } clk_state_e;

  localparam int DEF_PHI1_LEN = 3;
  localparam int DEF_PHI2_LEN = 3;
  localparam int DEF_GAP_LEN  = 1;
  localparam int DEF_CNT_W    = 4;
  localparam int DEF_CYC_W    = 16;

endpackage

// File: rtl/nmos_phase_timer.sv
// ---------------------------------------------------------------------------
// nmos_phase_timer
// Loadable down-counter shared by every phase of the clock generator.
// Loading len-1 on phase entry makes done rise on the phase's last cycle.
// Ports:
//   main_clk  : clock, rising edge
//   rst       : synchronous active-high reset (counter -> 0)
//   load      : load load_val this edge (takes priority over decrement)
//   load_val  : value to load (phase length minus one)
//   done      : counter is zero; the owning FSM leaves the phase this edge
// ---------------------------------------------------------------------------
module nmos_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             main_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero so an idle timer keeps reporting done.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/nmos_clk_gen.sv
// ---------------------------------------------------------------------------
// nmos_clk_gen
// Two-phase non-overlapping clock generator for the NMOS cell library.
// Runs PH1 -> GAP1 -> PH2 -> GAP2 per machine cycle, with continuous run,
// single-step and a machine-cycle counter. All outputs are flops.
// Ports:
//   main_clk   : master simulation clock, rising edge
//   R          : synchronous active-high reset, dominates everything
//   run_req    : level, run continuously; 0 stops at the end of the cycle
//   step       : pulse, run one machine cycle from IDLE (ignored when busy)
//   C1, C2     : PHI1 / PHI2 clock levels
//   busy       : high whenever not IDLE
//   cyc_cnt    : machine cycles started, wraps silently
//   phi1_start : one-cycle pulse on the first cycle of each PH1
// ---------------------------------------------------------------------------
module nmos_clk_gen
  import nmos_clk_pkg::*;
#(
  parameter int PHI1_LEN = DEF_PHI1_LEN,
  parameter int PHI2_LEN = DEF_PHI2_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CYC_W    = DEF_CYC_W
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic             run_req,
  input  logic             step,
  output logic             C1,
  output logic             C2,
  output logic             busy,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic             phi1_start
);

  localparam int LEN_MAX = (1 << CNT_W) - 1;

  if (PHI1_LEN < 1 || PHI2_LEN < 1) begin : g_zero_phase
    $error("nmos_clk_gen: PHI1_LEN and PHI2_LEN must be at least 1");
  end

  if (PHI1_LEN > LEN_MAX || PHI2_LEN > LEN_MAX || GAP_LEN > LEN_MAX) begin : g_len_ovf
    $error("nmos_clk_gen: a phase length does not fit in CNT_W bits");
  end

  localparam bit               HAS_GAP = (GAP_LEN > 0);
  localparam logic [CNT_W-1:0] PH1_LD  = CNT_W'(PHI1_LEN - 1);
  localparam logic [CNT_W-1:0] PH2_LD  = CNT_W'(PHI2_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = HAS_GAP ? CNT_W'(GAP_LEN - 1) : '0;

  clk_state_e       state;
  logic             single;
  logic             start;
  logic             cont;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  assign start = run_req | step;
  // single is cleared by any sampled run_req while busy, so raising run_req
  // during a stepped cycle turns it into a continuous run.
  assign cont  = run_req & ~single;

  nmos_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .main_clk (main_clk),
    .rst      (R),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer reload on every state change, with the length of the state being
  // entered. Going to IDLE parks the counter at zero.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = start;
        tmr_val  = PH1_LD;
      end
      ST_PH1: begin
        tmr_load = tmr_done;
        tmr_val  = HAS_GAP ? GAP_LD : PH2_LD;
      end
      ST_GAP1: begin
        tmr_load = tmr_done;
        tmr_val  = PH2_LD;
      end
      ST_PH2: begin
        tmr_load = tmr_done;
        tmr_val  = HAS_GAP ? GAP_LD : (cont ? PH1_LD : '0);
      end
      ST_GAP2: begin
        tmr_load = tmr_done;
        tmr_val  = cont ? PH1_LD : '0;
      end
      default: begin
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (R) begin
      state      <= ST_IDLE;
      C1         <= 1'b0;
      C2         <= 1'b0;
      busy       <= 1'b0;
      phi1_start <= 1'b0;
      cyc_cnt    <= '0;
      single     <= 1'b0;
    end else begin
      phi1_start <= 1'b0;
      if (run_req) begin
        single <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_PH1;
            C1         <= 1'b1;
            busy       <= 1'b1;
            phi1_start <= 1'b1;
            cyc_cnt    <= cyc_cnt + CYC_W'(1);
            single     <= step & ~run_req;
          end
        end
        ST_PH1: begin
          if (tmr_done) begin
            C1 <= 1'b0;
            if (HAS_GAP) begin
              state <= ST_GAP1;
            end else begin
              state <= ST_PH2;
              C2    <= 1'b1;
            end
          end
        end
        ST_GAP1: begin
          if (tmr_done) begin
            state <= ST_PH2;
            C2    <= 1'b1;
          end
        end
        ST_PH2: begin
          if (tmr_done) begin
            C2 <= 1'b0;
            if (HAS_GAP) begin
              state <= ST_GAP2;
            end else if (cont) begin
              state      <= ST_PH1;
              C1         <= 1'b1;
              phi1_start <= 1'b1;
              cyc_cnt    <= cyc_cnt + CYC_W'(1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_GAP2: begin
          if (tmr_done) begin
            if (cont) begin
              state      <= ST_PH1;
              C1         <= 1'b1;
              phi1_start <= 1'b1;
              cyc_cnt    <= cyc_cnt + CYC_W'(1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          C1    <= 1'b0;
          C2    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmos_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_nmos_clk_gen
// Directed bench for nmos_clk_gen: default configuration, a GAP_LEN=0
// configuration and a narrow cycle counter configuration.
// ---------------------------------------------------------------------------
module tb_nmos_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        R = 1'b1, run_req = 1'b0, step = 1'b0;
  logic        c1, c2, busy, ps;
  logic [15:0] cyc;

  // PHI1_LEN=1, PHI2_LEN=2, GAP_LEN=0
  logic        R_g = 1'b1, run_g = 1'b0, step_g = 1'b0;
  logic        c1_g, c2_g, busy_g, ps_g;
  logic [15:0] cyc_g;

  // CYC_W=4
  logic        R_c = 1'b1, run_c = 1'b0, step_c = 1'b0;
  logic        c1_c, c2_c, busy_c, ps_c;
  logic [3:0]  cyc_c;

  nmos_clk_gen dut (
    .main_clk (clk), .R (R), .run_req (run_req), .step (step),
    .C1 (c1), .C2 (c2), .busy (busy), .cyc_cnt (cyc), .phi1_start (ps)
  );

  nmos_clk_gen #(.PHI1_LEN(1), .PHI2_LEN(2), .GAP_LEN(0)) dut_g0 (
    .main_clk (clk), .R (R_g), .run_req (run_g), .step (step_g),
    .C1 (c1_g), .C2 (c2_g), .busy (busy_g), .cyc_cnt (cyc_g), .phi1_start (ps_g)
  );

  nmos_clk_gen #(.CYC_W(4)) dut_c4 (
    .main_clk (clk), .R (R_c), .run_req (run_c), .step (step_c),
    .C1 (c1_c), .C2 (c2_c), .busy (busy_c), .cyc_cnt (cyc_c), .phi1_start (ps_c)
  );

  // Expected C1/C2/phi1_start after edges 0..8 of a default-length run.
  logic [8:0] c1_pat = 9'b1_0000_0111;
  logic [8:0] c2_pat = 9'b0_0111_0000;
  logic [8:0] ps_pat = 9'b1_0000_0001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state
    tick();
    tick();
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_ps", ps, 0);

    // ---- continuous run, edges 0..8
    R = 1'b0;
    run_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("run_c1", c1, c1_pat[k]);
      chk("run_c2", c2, c2_pat[k]);
      chk("run_ps", ps, ps_pat[k]);
      chk("run_busy", busy, 1);
      chk("run_cyc", cyc, (k == 8) ? 2 : 1);
    end

    // ---- stop during PH2 of cycle 3 (PH2 at edges 20..22)
    for (int k = 9; k <= 20; k++) tick();
    chk("stop_ph2_c2", c2, 1);
    chk("stop_cyc_mid", cyc, 3);
    run_req = 1'b0;
    tick();
    tick();
    chk("stop_ph2_hold", c2, 1);
    tick();
    chk("stop_gap2_c2", c2, 0);
    chk("stop_gap2_busy", busy, 1);
    tick();
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_c1", c1, 0);
    chk("stop_cyc", cyc, 3);
    tick();
    tick();
    chk("stop_stay_busy", busy, 0);
    chk("stop_stay_c1", c1, 0);

    // ---- single step, with a step pulse inside the cycle that must be ignored
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("step_pre_cyc", cyc, 0);
    step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0 || k == 3) step = 1'b0;
      if (k == 2) step = 1'b1;
      chk("step_c1", c1, (k < 8) ? c1_pat[k] : 0);
      chk("step_c2", c2, (k < 8) ? c2_pat[k] : 0);
      chk("step_busy", busy, (k < 8) ? 1 : 0);
      chk("step_ps", ps, (k == 0) ? 1 : 0);
      chk("step_cyc", cyc, 1);
    end

    // ---- reset mid-PH1 with run_req held
    run_req = 1'b1;
    tick();
    tick();
    chk("rmid_pre_c1", c1, 1);
    chk("rmid_pre_cyc", cyc, 2);
    R = 1'b1;
    tick();
    chk("rmid_c1", c1, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_cyc", cyc, 0);
    chk("rmid_ps", ps, 0);
    R = 1'b0;
    tick();
    chk("rmid_restart_c1", c1, 1);
    chk("rmid_restart_busy", busy, 1);
    chk("rmid_restart_cyc", cyc, 1);
    chk("rmid_restart_ps", ps, 1);
    run_req = 1'b0;

    // ---- GAP_LEN=0, PHI1_LEN=1, PHI2_LEN=2: period 3
    R_g = 1'b0;
    run_g = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("g0_c1", c1_g, (k % 3 == 0) ? 1 : 0);
      chk("g0_c2", c2_g, (k % 3 != 0) ? 1 : 0);
      chk("g0_overlap", c1_g & c2_g, 0);
      chk("g0_ps", ps_g, (k % 3 == 0) ? 1 : 0);
      chk("g0_cyc", cyc_g, k / 3 + 1);
    end

    // ---- CYC_W=4: 17 machine cycles, counter wraps 15 -> 0 -> 1
    R_c = 1'b0;
    run_c = 1'b1;
    tick();
    chk("c4_first_cyc", cyc_c, 1);
    for (int e = 1; e <= 128; e++) begin
      tick();
      if (e == 112) begin
        chk("c4_cyc15", cyc_c, 15);
        chk("c4_ps15", ps_c, 1);
      end
      if (e == 120) begin
        chk("c4_cyc_wrap", cyc_c, 0);
        chk("c4_ps_wrap", ps_c, 1);
        chk("c4_c1_wrap", c1_c, 1);
        chk("c4_busy_wrap", busy_c, 1);
      end
      if (e == 123) begin
        chk("c4_gap1_c1", c1_c, 0);
        chk("c4_gap1_c2", c2_c, 0);
      end
      if (e == 124) chk("c4_ph2_c2", c2_c, 1);
      if (e == 128) chk("c4_cyc_after", cyc_c, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
